// File: rtl/uart_rx_fifo_if.sv
// Byte-receive / word-read bus between the UART receiver, the APB read path
// and the receive FIFO. Parameter AW is the FIFO pointer width.
interface uart_rx_fifo_if #(
   parameter int unsigned AW = 4
);
   logic          rx_done;
   logic [7:0]    rx_data;
   logic          rd_req;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          ovf_clr;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;

   // Receiver and APB side: drives requests, observes status
   modport master (
      output rx_done, rx_data, rd_req, ovf_clr,
      input  rd_data, rd_valid, empty, full, count, overflow
   );

   // FIFO side
   modport slave (
      input  rx_done, rx_data, rd_req, ovf_clr,
      output rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers received bytes and returns them as 32-bit read
// words {16'h0, 8'h80, byte}. Sticky overflow when a byte arrives while full.
// Optional macro UART_RX_ZERO_DROP_EN: received 8'h00 bytes are discarded.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic           clk,
   input  logic           resetn,
   uart_rx_fifo_if.slave  bus
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 8;
   localparam int unsigned WW = 32;

   logic [DW-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0] count_q,    count_d;
   logic          empty_q,    empty_d;
   logic          full_q,     full_d;
   logic          ovf_q,      ovf_d;
   logic [WW-1:0] rd_data_q,  rd_data_d;
   logic          rd_valid_q, rd_valid_d;

   logic          byte_ok_c;
   logic          pop_c;
   logic          push_c;
   logic          drop_c;

   // Byte qualification: optionally treat 8'h00 as line noise
`ifdef UART_RX_ZERO_DROP_EN
   assign byte_ok_c = (bus.rx_data != 8'h00);
`else
   assign byte_ok_c = 1'b1;
`endif

   // Accept decisions; a pop frees the slot a same-edge push needs when full
   assign pop_c  = bus.rd_req & ~empty_q;
   assign push_c = bus.rx_done & byte_ok_c & (~full_q | pop_c);
   assign drop_c = bus.rx_done & byte_ok_c & full_q & ~pop_c;

   // Next-state computation for pointers, occupancy, flags and read word
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = bus.rd_req;

      if (push_c) begin
         wr_ptr_d = AW'(wr_ptr_q + AW'(1));
      end
      if (pop_c) begin
         rd_ptr_d = AW'(rd_ptr_q + AW'(1));
      end
      count_d = CW'(count_q + CW'(push_c) - CW'(pop_c));

      if (bus.rd_req) begin
         rd_data_d = pop_c ? {16'h0000, 8'h80, mem_q[rd_ptr_q]} : WW'(0);
      end

      // Set wins over clear
      if (drop_c) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end

      empty_d = (count_d == CW'(0));
      full_d  = (count_d == CW'(DEPTH));
   end

   // Control and status registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Byte storage, intentionally not reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= bus.rx_data;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic clk;
   logic resetn;
   int   checks;
   int   passes;
   logic [7:0] exp_q[$];

   uart_rx_fifo_if #(.AW(AW)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic pop(output logic [31:0] d, output logic v);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      d = bus.rd_data;
      v = bus.rd_valid;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.rd_data !== 32'h0 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 ||
          bus.full !== 1'b0 || bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
         $display("FAIL reset_state: rd_data=%h rd_valid=%b empty=%b full=%b count=%0d ovf=%b, want 0/0/1/0/0/0",
                  bus.rd_data, bus.rd_valid, bus.empty, bus.full, bus.count, bus.overflow);
      end else passes++;
   endtask

   task automatic test_basic();
      logic [31:0] d;
      logic v;
      push(8'h41);
      push(8'h42);
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8041 || v !== 1'b1) $display("FAIL basic_pop1: got %h v=%b, want 00008041 v=1", d, v);
      else passes++;
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8042 || v !== 1'b1) $display("FAIL basic_pop2: got %h v=%b, want 00008042 v=1", d, v);
      else passes++;
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0000_8042 || bus.empty !== 1'b1)
         $display("FAIL basic_hold: rd_valid=%b rd_data=%h empty=%b, want 0 00008042 1",
                  bus.rd_valid, bus.rd_data, bus.empty);
      else passes++;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic v;
      for (int i = 1; i <= 17; i++) push(8'(i));
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b1)
         $display("FAIL ovf_fill: full=%b count=%0d ovf=%b, want 1 16 1", bus.full, bus.count, bus.overflow);
      else passes++;
      for (int i = 1; i <= 16; i++) begin
         pop(d, v);
         checks++;
         if (d !== {24'h000080, 8'(i)}) $display("FAIL ovf_pop%0d: got %h, want %h", i, d, {24'h000080, 8'(i)});
         else passes++;
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.count !== 5'd0)
         $display("FAIL ovf_drained: empty=%b count=%0d, want 1 0", bus.empty, bus.count);
      else passes++;
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b, want 0", bus.overflow);
      else passes++;
   endtask

   task automatic test_empty_read();
      logic [31:0] d;
      logic v;
      pop(d, v);
      checks++;
      if (d !== 32'h0 || v !== 1'b1 || bus.count !== 5'd0)
         $display("FAIL empty_read: got %h v=%b count=%0d, want 0 1 0", d, v, bus.count);
      else passes++;
      bus.rx_done = 1'b1;
      bus.rx_data = 8'h33;
      pop(d, v);
      bus.rx_done = 1'b0;
      checks++;
      if (d !== 32'h0 || v !== 1'b1 || bus.count !== 5'd1 || bus.empty !== 1'b0)
         $display("FAIL empty_simul: got %h v=%b count=%0d empty=%b, want 0 1 1 0", d, v, bus.count, bus.empty);
      else passes++;
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8033 || bus.empty !== 1'b1)
         $display("FAIL empty_simul_pop: got %h empty=%b, want 00008033 1", d, bus.empty);
      else passes++;
   endtask

   task automatic test_full_simul();
      logic [31:0] d;
      logic v;
      for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
      bus.rx_done = 1'b1;
      bus.rx_data = 8'h55;
      pop(d, v);
      bus.rx_done = 1'b0;
      checks++;
      if (d !== 32'h0000_8060 || bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1)
         $display("FAIL full_simul: got %h count=%0d ovf=%b full=%b, want 00008060 16 0 1",
                  d, bus.count, bus.overflow, bus.full);
      else passes++;
      for (int i = 1; i < 16; i++) begin
         pop(d, v);
         checks++;
         if (d !== {24'h000080, 8'h60 + 8'(i)})
            $display("FAIL full_simul_pop%0d: got %h, want %h", i, d, {24'h000080, 8'h60 + 8'(i)});
         else passes++;
      end
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8055 || bus.empty !== 1'b1)
         $display("FAIL full_simul_last: got %h empty=%b, want 00008055 1", d, bus.empty);
      else passes++;
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      logic v;
      logic [7:0] e;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         push(8'hA0 + 8'(i));
         exp_q.push_back(8'hA0 + 8'(i));
      end
      for (int i = 4; i < 40; i++) begin
         push(8'hA0 + 8'(i));
         exp_q.push_back(8'hA0 + 8'(i));
         pop(d, v);
         e = exp_q.pop_front();
         checks++;
         if (d !== {24'h000080, e}) $display("FAIL wrap_pop%0d: got %h, want %h", i, d, {24'h000080, e});
         else passes++;
      end
      while (exp_q.size() > 0) begin
         pop(d, v);
         e = exp_q.pop_front();
         checks++;
         if (d !== {24'h000080, e}) $display("FAIL wrap_drain: got %h, want %h", d, {24'h000080, e});
         else passes++;
      end
      push(8'h11);
      push(8'h22);
      push(8'h33);
      bus.rd_req = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      bus.rd_req = 1'b0;
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_data !== 32'h0 || bus.rd_valid !== 1'b0)
         $display("FAIL mid_reset: count=%0d empty=%b rd_data=%h rd_valid=%b, want 0 1 0 0",
                  bus.count, bus.empty, bus.rd_data, bus.rd_valid);
      else passes++;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      push(8'h77);
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8077 || bus.empty !== 1'b1)
         $display("FAIL post_reset: got %h empty=%b, want 00008077 1", d, bus.empty);
      else passes++;
   endtask

   task automatic test_zero();
      logic [31:0] d;
      logic v;
      push(8'h00);
`ifdef UART_RX_ZERO_DROP_EN
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1)
         $display("FAIL zero_drop: count=%0d empty=%b, want 0 1", bus.count, bus.empty);
      else passes++;
`else
      pop(d, v);
      checks++;
      if (d !== 32'h0000_8000 || bus.empty !== 1'b1)
         $display("FAIL zero_byte: got %h empty=%b, want 00008000 1", d, bus.empty);
      else passes++;
`endif
      for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
      push(8'hEE);
      checks++;
      if (bus.overflow !== 1'b1) $display("FAIL ovf_set: got %b, want 1", bus.overflow);
      else passes++;
      bus.ovf_clr = 1'b1;
      push(8'hEF);
      bus.ovf_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b, want 1", bus.overflow);
      else passes++;
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) $display("FAIL ovf_clr_only: got %b, want 0", bus.overflow);
      else passes++;
`ifdef UART_RX_ZERO_DROP_EN
      push(8'h00);
      checks++;
      if (bus.overflow !== 1'b0 || bus.count !== 5'd16)
         $display("FAIL zero_full: ovf=%b count=%0d, want 0 16", bus.overflow, bus.count);
      else passes++;
`endif
      for (int i = 0; i < 16; i++) begin
         pop(d, v);
         checks++;
         if (d !== {24'h000080, 8'hC0 + 8'(i)})
            $display("FAIL zero_drain%0d: got %h, want %h", i, d, {24'h000080, 8'hC0 + 8'(i)});
         else passes++;
      end
   endtask

   initial begin
      checks      = 0;
      passes      = 0;
      resetn      = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_req  = 1'b0;
      bus.ovf_clr = 1'b0;
      tick();
      tick();
      test_reset();
      resetn = 1'b1;
      tick();
      test_basic();
      test_overflow();
      test_empty_read();
      test_full_simul();
      test_wrap();
      test_zero();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of byte entries; power of two, 2..256.
REQ-002 SHALL have parameter AW, default 4, meaning pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_done  input  1  one-cycle pulse from the UART receiver: byte available.
REQ-006 SHALL have port rx_data  input  8  received byte, valid when rx_done=1.
REQ-007 SHALL have port rd_req  input  1  one-cycle pop request from the APB read path.
REQ-008 SHALL have port rd_data  output  32  registered read word.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse: rd_data updated in response to rd_req.
REQ-010 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-011 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-013 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: at least one byte dropped while full.

Function
REQ-015 SHALL push rx_data at the tail on a clk edge with rx_done=1 and the FIFO not full, or full with a simultaneous accepted pop.
REQ-016 SHALL pop the head entry on a clk edge with rd_req=1 and the FIFO not empty.
REQ-017 SHALL, on a pop, load rd_data with {16'h0, 8'h80, head byte} on the same edge; latency rd_req -> rd_data = 1 cycle.
REQ-018 SHALL, on rd_req while empty, load rd_data with 32'h0 and leave pointers unchanged (no underflow).
REQ-019 SHALL assert rd_valid for exactly one cycle after every rd_req, whether empty or not.
REQ-020 SHALL hold rd_data unchanged between rd_req pulses.
REQ-021 SHALL, with rx_done=1 while full and no pop on the same edge, drop the byte, leave contents unchanged and set overflow.
REQ-022 SHALL, with rx_done and rd_req on the same edge while empty, store the byte and return 32'h0; count ends at 1.
REQ-023 SHALL, with rx_done and rd_req on the same edge while non-empty, pop the head, store the new byte, and keep count unchanged.
REQ-024 SHALL wrap read and write pointers from DEPTH-1 to 0 without any gap.
REQ-025 SHALL keep count = writes accepted - pops accepted, and drive empty=(count==0) and full=(count==DEPTH), all registered.
REQ-026 SHALL clear overflow on ovf_clr=1 unless a drop occurs on the same edge, in which case overflow stays 1 (set wins).
REQ-027 SHALL keep FIFO storage out of reset; only pointers, count, flags and rd_data are reset.

Reset
REQ-028 SHALL, while resetn=0, force rd_data=32'h0, rd_valid=0, empty=1, full=0, count=0, overflow=0, both pointers=0.
REQ-029 SHALL discard all buffered bytes and any in-flight pop on reset assertion mid-operation; the first push after release lands at entry 0.
REQ-030 SHALL ignore rx_done, rd_req and ovf_clr on the first edge after resetn deasserts only if the edge coincides with deassertion; they take effect from the next edge.

Configuration
REQ-031 SHALL, with macro UART_RX_ZERO_DROP_EN defined, discard any received byte equal to 8'h00: no push, no count change, no overflow set, even when full.
REQ-032 SHALL, without UART_RX_ZERO_DROP_EN, treat 8'h00 like any other byte and return it as 32'h0000_8000.

Verification
REQ-033 SHALL cover: push 8'h41, 8'h42, then two rd_req -> rd_data 32'h0000_8041 then 32'h0000_8042, each with rd_valid 1 cycle after rd_req; empty=1 at end.
REQ-034 SHALL cover: DEPTH=16, push 17 bytes 0x01..0x11 -> full=1, count=16, overflow=1; 16 pops return 0x01..0x10; 0x11 is lost.
REQ-035 SHALL cover: rd_req while empty -> rd_data 32'h0, rd_valid=1, count stays 0; then rx_done with rd_req on the same edge while empty -> rd_data 32'h0, count=1.
REQ-036 SHALL cover: full FIFO, rx_done 0x55 and rd_req on the same edge -> head returned, count stays 16, overflow stays 0, 0x55 read last.
REQ-037 SHALL cover: push 20+ bytes with interleaved pops to cross pointer wrap twice -> output order equals input order; then resetn pulse mid-stream -> count=0, empty=1, rd_data=0.
REQ-038 SHALL cover: push 8'h00 -> with UART_RX_ZERO_DROP_EN count stays 0; without it rd_req returns 32'h0000_8000; ovf_clr and drop on the same edge -> overflow stays 1.
